// File: rtl/shift_s_to_p_pkg.sv
// ---------------------------------------------------------------------------
// shift_s_to_p_pkg
// Shared definitions for the serial-to-parallel receiver:
//   - DW_DEFAULT     : default payload width (bits per frame)
//   - cnt_width()    : bit-counter width needed for a given payload width
//   - CNT_W_DEFAULT  : counter width for the default payload width
//   - state_e        : receiver FSM states (ST_PARITY is only reachable when
//                      SHIFT_S_TO_P_PARITY_EN is defined)
// ---------------------------------------------------------------------------
package shift_s_to_p_pkg;

    localparam int DW_DEFAULT = 8;

    // The counter only has to hold 0..DW-1.
    function automatic int cnt_width(input int dw);
        return (dw > 2) ? $clog2(dw) : 1;
    endfunction

    localparam int CNT_W_DEFAULT = cnt_width(DW_DEFAULT);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2
    } state_e;

endpackage

// File: rtl/s2p_shreg.sv
// ---------------------------------------------------------------------------
// s2p_shreg
// Shift register and bit counter of the serial-to-parallel receiver.
//   clk_i   : clock, state changes on posedge
//   rst_ni  : asynchronous active-low reset (clears register and counter)
//   load_i  : frame start: sin_i becomes bit 0, counter = 1
//   shift_i : shift sin_i in at the LSB end, counter + 1
//   sin_i   : serial data, MSB first
//   sreg_o  : current shift register contents
//   cnt_o   : number of bits collected in the current frame
// load_i has priority over shift_i.
// ---------------------------------------------------------------------------
module s2p_shreg #(
    parameter int DW = 8,
    parameter int CW = 3
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          load_i,
    input  logic          shift_i,
    input  logic          sin_i,
    output logic [DW-1:0] sreg_o,
    output logic [CW-1:0] cnt_o
);

    logic [DW-1:0] sreg_q, sreg_d;
    logic [CW-1:0] cnt_q,  cnt_d;

    always_comb begin
        sreg_d = sreg_q;
        cnt_d  = cnt_q;
        if (load_i) begin
            // Older bits are shifted out before the frame completes, but
            // clearing them keeps the register contents easy to read.
            sreg_d = {{(DW-1){1'b0}}, sin_i};
            cnt_d  = CW'(1);
        end else if (shift_i) begin
            sreg_d = {sreg_q[DW-2:0], sin_i};
            cnt_d  = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sreg_q <= '0;
            cnt_q  <= '0;
        end else begin
            sreg_q <= sreg_d;
            cnt_q  <= cnt_d;
        end
    end

    assign sreg_o = sreg_q;
    assign cnt_o  = cnt_q;

endmodule

// File: rtl/shift_s_to_p.sv
// ---------------------------------------------------------------------------
// shift_s_to_p
// Serial-to-parallel receiver: collects DW bits (MSB first) after a start
// strobe and presents them as a parallel frame with a valid/ready output.
//   Clock      : clock, all state changes on posedge
//   rst        : asynchronous active-low reset
//   sIn        : serial data, MSB first, one bit per Clock
//   start      : high in the cycle sIn carries the frame MSB (also restarts
//                a frame in progress)
//   data       : last completed frame
//   valid      : data holds an unconsumed frame
//   ready      : consumer takes data at a posedge where valid && ready
//   overrun    : sticky, a completed frame was dropped because data was full
//   ovr_clr    : synchronous clear of overrun (a same-edge overrun wins)
//   parity_err : parity result of the frame in data
//   state_o    : current FSM state (state_e encoding), for observation
// Handshake: a frame is transferred at a posedge where valid && ready; data is
// held stable while valid && !ready, and valid only drops on a transfer edge
// at which no new frame completes.
// Optional feature macro SHIFT_S_TO_P_PARITY_EN: one even-parity bit follows
// bit DW-1; completion moves to that edge and parity_err reports
// XOR(frame, parity bit). Without it parity_err is tied to 0.
// ---------------------------------------------------------------------------
module shift_s_to_p
    import shift_s_to_p_pkg::*;
#(
    parameter int DW = DW_DEFAULT
) (
    input  logic          Clock,
    input  logic          rst,
    input  logic          sIn,
    input  logic          start,
    output logic [DW-1:0] data,
    output logic          valid,
    input  logic          ready,
    output logic          overrun,
    input  logic          ovr_clr,
    output logic          parity_err,
    output logic [1:0]    state_o
);

    localparam int CW = cnt_width(DW);

    state_e        state_q, state_d;
    logic [DW-1:0] sreg;
    logic [CW-1:0] cnt;
    logic          load, shift;
    logic          done;
    logic [DW-1:0] frame;
    logic          accept;
    logic [DW-1:0] data_q, data_d;
    logic          valid_q, valid_d;
    logic          ovr_q, ovr_d;
`ifdef SHIFT_S_TO_P_PARITY_EN
    logic          perr_new;
    logic          perr_q, perr_d;
`endif

    s2p_shreg #(
        .DW (DW),
        .CW (CW)
    ) u_shreg (
        .clk_i   (Clock),
        .rst_ni  (rst),
        .load_i  (load),
        .shift_i (shift),
        .sin_i   (sIn),
        .sreg_o  (sreg),
        .cnt_o   (cnt)
    );

    // Next state, shift control and frame completion.
    always_comb begin
        state_d  = state_q;
        load     = 1'b0;
        shift    = 1'b0;
        done     = 1'b0;
        // Without parity the frame completes on the edge that samples the
        // last bit, so the full frame is the register plus the live bit.
        frame    = {sreg[DW-2:0], sIn};
`ifdef SHIFT_S_TO_P_PARITY_EN
        perr_new = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (start) begin
                    load = 1'b1;             // abort and restart
                end else begin
                    shift = 1'b1;
                    if (cnt == CW'(DW-1)) begin
`ifdef SHIFT_S_TO_P_PARITY_EN
                        state_d = ST_PARITY;
`else
                        done    = 1'b1;
                        state_d = ST_IDLE;
`endif
                    end
                end
            end
`ifdef SHIFT_S_TO_P_PARITY_EN
            ST_PARITY: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = ST_SHIFT;
                end else begin
                    done     = 1'b1;
                    frame    = sreg;         // all DW bits already shifted in
                    perr_new = ^{sreg, sIn};
                    state_d  = ST_IDLE;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    // Output register and flags.
    assign accept = !valid_q || ready;

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;
`ifdef SHIFT_S_TO_P_PARITY_EN
        perr_d  = perr_q;
`endif
        if (done && accept) begin
            data_d  = frame;
            valid_d = 1'b1;
`ifdef SHIFT_S_TO_P_PARITY_EN
            perr_d  = perr_new;
`endif
        end else if (valid_q && ready) begin
            valid_d = 1'b0;
        end
        if (done && !accept) begin
            ovr_d = 1'b1;
        end else if (ovr_clr) begin
            ovr_d = 1'b0;
        end
    end

    always_ff @(posedge Clock or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
`ifdef SHIFT_S_TO_P_PARITY_EN
            perr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
`ifdef SHIFT_S_TO_P_PARITY_EN
            perr_q  <= perr_d;
`endif
        end
    end

    assign data    = data_q;
    assign valid   = valid_q;
    assign overrun = ovr_q;
    assign state_o = state_q;
`ifdef SHIFT_S_TO_P_PARITY_EN
    assign parity_err = perr_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_shift_s_to_p.sv
module tb_shift_s_to_p;

    localparam int DW = 8;
`ifdef SHIFT_S_TO_P_PARITY_EN
    localparam int FLEN = DW + 1;
`else
    localparam int FLEN = DW;
`endif

    logic          Clock;
    logic          rst;
    logic          sIn;
    logic          start;
    logic [DW-1:0] data;
    logic          valid;
    logic          ready;
    logic          overrun;
    logic          ovr_clr;
    logic          parity_err;
    logic [1:0]    state_o;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: bits collected since the last start, plus output view.
    bit            m_bits[$];
    bit            m_busy;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ovr;
    logic          m_perr;

    shift_s_to_p #(.DW(DW)) dut (
        .Clock      (Clock),
        .rst        (rst),
        .sIn        (sIn),
        .start      (start),
        .data       (data),
        .valid      (valid),
        .ready      (ready),
        .overrun    (overrun),
        .ovr_clr    (ovr_clr),
        .parity_err (parity_err),
        .state_o    (state_o)
    );

    // ---------------- clock / reset ----------------
    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic model_reset();
        m_bits.delete();
        m_busy  = 0;
        m_data  = '0;
        m_valid = 1'b0;
        m_ovr   = 1'b0;
        m_perr  = 1'b0;
    endtask

    // Applies one clock edge of the receive rules to the model using the
    // inputs currently driven.
    task automatic model_step();
        bit            done;
        bit            acc;
        bit            ovr_ev;
        logic [DW-1:0] fr;
        logic          par;
        done = 0;
        fr   = '0;
        par  = 1'b0;
        if (start) begin
            m_bits.delete();
            m_bits.push_back(sIn);
            m_busy = 1;
        end else if (m_busy) begin
            m_bits.push_back(sIn);
        end
        if (m_busy && m_bits.size() == FLEN) begin
            done = 1;
            for (int i = 0; i < DW; i++) fr = fr * 2 + DW'(m_bits[i]);
            for (int i = 0; i < FLEN; i++) par = par ^ m_bits[i];
            m_busy = 0;
            m_bits.delete();
        end
`ifndef SHIFT_S_TO_P_PARITY_EN
        par = 1'b0;
`endif
        acc    = !m_valid || ready;
        ovr_ev = done && !acc;
        if (done && acc) begin
            m_data  = fr;
            m_valid = 1'b1;
            m_perr  = par;
        end else if (m_valid && ready) begin
            m_valid = 1'b0;
        end
        if (ovr_ev) m_ovr = 1'b1;
        else if (ovr_clr) m_ovr = 1'b0;
    endtask

    // One cycle: model follows the edge, outputs sampled 1 time unit later.
    task automatic tick();
        model_step();
        @(posedge Clock);
        #1;
    endtask

    // ---------------- driver ----------------
    task automatic drive_frame(input logic [DW-1:0] f, input logic pbit,
                               input logic rdy_last);
        for (int i = 0; i < FLEN; i++) begin
            start = (i == 0);
            sIn   = (i < DW) ? f[DW-1-i] : pbit;
            if (i == FLEN - 1) ready = rdy_last;
            tick();
        end
        start = 1'b0;
        sIn   = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b0; start = 1'b0; sIn = 1'b0; ready = 1'b0; ovr_clr = 1'b0;
        model_reset();
        #12;
        n_checks++;
        if ({data, valid, overrun, parity_err, state_o} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got data=%h valid=%b ovr=%b perr=%b st=%0d required all 0",
                     data, valid, overrun, parity_err, state_o);
        end
        rst = 1'b1;
    endtask

    task automatic test_basic_a5();
        logic [DW-1:0] f;
        f = 8'hA5;
        ready = 1'b1;
        for (int i = 0; i < FLEN; i++) begin
            start = (i == 0);
            sIn   = (i < DW) ? f[DW-1-i] : 1'b0;
            tick();
            if (i == FLEN - 2) begin
                n_checks++;
                if (valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL a5_valid_early: got %b required 0", valid);
                end
            end
        end
        start = 1'b0; sIn = 1'b0;
        n_checks++;
        if (data !== 8'hA5 || valid !== 1'b1 || parity_err !== 1'b0) begin
            n_fail++;
            $display("FAIL a5_frame: got data=%h valid=%b perr=%b required a5/1/0", data, valid, parity_err);
        end
        tick();
        n_checks++;
        if (valid !== 1'b0 || data !== 8'hA5) begin
            n_fail++;
            $display("FAIL a5_consume: got valid=%b data=%h required 0/a5", valid, data);
        end
    endtask

    task automatic test_overrun();
        ready = 1'b0;
        drive_frame(8'h3C, 1'b0, 1'b0);
        n_checks++;
        if (data !== 8'h3C || valid !== 1'b1 || overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL ovr_first: got data=%h valid=%b ovr=%b required 3c/1/0", data, valid, overrun);
        end
        drive_frame(8'hFF, 1'b0, 1'b0);
        n_checks++;
        if (data !== 8'h3C || valid !== 1'b1 || overrun !== 1'b1) begin
            n_fail++;
            $display("FAIL ovr_drop: got data=%h valid=%b ovr=%b required 3c/1/1", data, valid, overrun);
        end
        ovr_clr = 1'b1;
        tick();
        ovr_clr = 1'b0;
        n_checks++;
        if (overrun !== 1'b0 || valid !== 1'b1 || data !== 8'h3C) begin
            n_fail++;
            $display("FAIL ovr_clear: got ovr=%b valid=%b data=%h required 0/1/3c", overrun, valid, data);
        end
    endtask

    task automatic test_ready_at_complete();
        drive_frame(8'h81, 1'b0, 1'b1);
        n_checks++;
        if (data !== 8'h81 || valid !== 1'b1 || overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL swap_81: got data=%h valid=%b ovr=%b required 81/1/0", data, valid, overrun);
        end
        tick();
        n_checks++;
        if (valid !== 1'b0) begin
            n_fail++;
            $display("FAIL swap_consume: got valid=%b required 0", valid);
        end
    endtask

    task automatic test_restart();
        ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            start = (i == 0);
            sIn   = 1'b1;
            tick();
        end
        drive_frame(8'h0F, 1'b0, 1'b1);
        n_checks++;
        if (data !== 8'h0F || valid !== 1'b1) begin
            n_fail++;
            $display("FAIL restart_0f: got data=%h valid=%b required 0f/1", data, valid);
        end
        n_checks++;
        if ({data, valid, overrun, parity_err} !== {m_data, m_valid, m_ovr, m_perr}) begin
            n_fail++;
            $display("FAIL restart_model: got %h required %h",
                     {data, valid, overrun, parity_err}, {m_data, m_valid, m_ovr, m_perr});
        end
        tick();
    endtask

    task automatic test_async_reset();
        ready = 1'b0;
        drive_frame(8'h5A, 1'b0, 1'b0);
        drive_frame(8'hC3, 1'b0, 1'b0);   // dropped, sets overrun
        for (int i = 0; i < 3; i++) begin
            start = (i == 0);
            sIn   = 1'b1;
            tick();
        end
        start = 1'b0;
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if ({data, valid, overrun, parity_err, state_o} !== '0) begin
            n_fail++;
            $display("FAIL async_reset: got data=%h valid=%b ovr=%b perr=%b st=%0d required all 0",
                     data, valid, overrun, parity_err, state_o);
        end
        #2;
        rst = 1'b1;
        // Bits without a start strobe must not form a frame.
        sIn = 1'b1;
        for (int i = 0; i < 2 * FLEN; i++) tick();
        n_checks++;
        if (valid !== 1'b0) begin
            n_fail++;
            $display("FAIL no_start_frame: got valid=%b required 0", valid);
        end
        ready = 1'b1;
        drive_frame(8'h12, 1'b0, 1'b1);
        n_checks++;
        if (data !== 8'h12 || valid !== 1'b1 || overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_12: got data=%h valid=%b ovr=%b required 12/1/0", data, valid, overrun);
        end
        tick();
    endtask

    task automatic test_parity();
        ready = 1'b1;
        drive_frame(8'hA5, 1'b0, 1'b1);
        n_checks++;
        if (data !== 8'hA5 || valid !== 1'b1 || parity_err !== 1'b0) begin
            n_fail++;
            $display("FAIL parity_good: got data=%h valid=%b perr=%b required a5/1/0", data, valid, parity_err);
        end
        drive_frame(8'hA5, 1'b1, 1'b1);
`ifdef SHIFT_S_TO_P_PARITY_EN
        n_checks++;
        if (data !== 8'hA5 || valid !== 1'b1 || parity_err !== 1'b1) begin
            n_fail++;
            $display("FAIL parity_bad: got data=%h valid=%b perr=%b required a5/1/1", data, valid, parity_err);
        end
`else
        n_checks++;
        if (parity_err !== 1'b0 || data !== 8'hA5 || valid !== 1'b1) begin
            n_fail++;
            $display("FAIL parity_tied: got perr=%b data=%h valid=%b required 0/a5/1", parity_err, data, valid);
        end
`endif
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            start   = ($urandom_range(0, 9) == 0);
            sIn     = 1'($urandom_range(0, 1));
            ready   = ($urandom_range(0, 2) == 0);
            ovr_clr = ($urandom_range(0, 15) == 0);
            tick();
            n_checks++;
            if ({data, valid, overrun, parity_err} !== {m_data, m_valid, m_ovr, m_perr}) begin
                n_fail++;
                $display("FAIL random_cycle%0d: got data=%h v=%b o=%b p=%b required data=%h v=%b o=%b p=%b",
                         c, data, valid, overrun, parity_err, m_data, m_valid, m_ovr, m_perr);
            end
        end
        start = 1'b0; ovr_clr = 1'b0;
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_basic_a5();
        test_overrun();
        test_ready_at_complete();
        test_restart();
        test_async_reset();
        test_parity();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/shift_s_to_p.md
SHIFT_S_TO_P -- requirements
Module: shift_s_to_p

Interface
REQ-001 SHALL have parameter DW, default 8: payload bits per frame.
REQ-002 SHALL have port Clock, input, 1: sole clock; all state changes on its posedge.
REQ-003 SHALL have port rst, input, 1: reset, asynchronous, active-low.
REQ-004 SHALL have port sIn, input, 1: serial data, MSB first, one bit per Clock, driven by the upstream ShiftPToS-style shifter.
REQ-005 SHALL have port start, input, 1: frame-start strobe, high in the cycle sIn carries the frame MSB.
REQ-006 SHALL have port data, output, DW: last completed frame.
REQ-007 SHALL have port valid, output, 1: data holds an unconsumed frame.
REQ-008 SHALL have port ready, input, 1: consumer accepts data when valid && ready at a posedge.
REQ-009 SHALL have port overrun, output, 1: sticky; a completed frame was dropped.
REQ-010 SHALL have port ovr_clr, input, 1: synchronous clear of overrun.
REQ-011 SHALL have port parity_err, output, 1: parity check result of the frame in data.

Function
REQ-012 SHALL run FSM states IDLE, SHIFT, PARITY (PARITY only with macro, REQ-024).
REQ-013 SHALL, in IDLE with start=1, sample sIn into shift register bit 0, set bit counter to 1 and go to SHIFT; start=0 stays IDLE, sIn ignored.
REQ-014 SHALL, in SHIFT, shift {sreg[DW-2:0], sIn} each posedge and increment the counter.
REQ-015 SHALL complete the frame at the posedge sampling bit DW-1 (counter = DW-1): go to IDLE (or PARITY), total DW consecutive samples including the start edge.
REQ-016 SHALL, on frame completion with valid=0 or ready=1, load data with the full frame and set valid=1 at that same edge (valid visible DW cycles after the start cycle).
REQ-017 SHALL, on frame completion with valid=1 and ready=0, keep data unchanged, drop the frame, set overrun=1.
REQ-018 SHALL clear valid at a posedge with valid && ready unless a frame completes at that edge (REQ-016 then keeps valid=1).
REQ-019 SHALL treat start=1 in SHIFT or PARITY as abort-and-restart: discard partial frame, sample sIn as new MSB, counter=1, no flags change.
REQ-020 SHALL clear overrun on ovr_clr=1 unless an overrun event occurs at the same edge (set wins).
REQ-021 SHALL keep data stable while valid=1 and ready=0.

Reset
REQ-022 SHALL, while rst=0, force state=IDLE, counter=0, shift register=0, data=0, valid=0, overrun=0, parity_err=0, independent of Clock.
REQ-023 SHALL, on reset mid-frame, discard the partial frame; first frame after release requires a fresh start.

Configuration
REQ-024 SHALL, with SHIFT_S_TO_P_PARITY_EN defined, expect one even-parity bit on sIn in the cycle after bit DW-1 (state PARITY); completion (REQ-016/017) moves to that edge; parity_err=1 when XOR(frame, parity bit)=1, loaded with data.
REQ-025 SHALL, without SHIFT_S_TO_P_PARITY_EN, omit PARITY state, complete per REQ-015 and tie parity_err to 0.

Structure
REQ-026 SHALL place the FSM state enum, DW default and counter width constant in package shift_s_to_p_pkg.
REQ-027 SHALL implement shift register plus bit counter as sub-module s2p_shreg; FSM, output register and flags stay in shift_s_to_p.

Verification
REQ-028 SHALL test: reset, start at cycle 0, sIn=1,0,1,0,0,1,0,1, ready=1 -> data=8'hA5, valid high one cycle after 8th bit, cleared next edge.
REQ-029 SHALL test: frame 8'h3C with ready=0, then frame 8'hFF -> data stays 8'h3C, overrun=1; ovr_clr pulse -> overrun=0.
REQ-030 SHALL test: ready=1 at the completion edge of frame 8'h81 while 8'h3C valid -> data=8'h81, valid stays 1, overrun=0.
REQ-031 SHALL test: start re-asserted after 4 bits of 8'hF0, then full 8'h0F -> data=8'h0F only.
REQ-032 SHALL test: rst=0 asynchronously mid-frame -> all outputs 0 before next edge; following frame 8'h12 received correctly.
REQ-033 SHALL test (PARITY_EN): 8'hA5 with parity 0 -> parity_err=0; parity 1 -> parity_err=1, valid=1.
